// File: rtl/timer_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_scheduler_if                                               |
// | Request, timer-control and completion signals of the scheduler.  |
// | Option: WATCHDOG_EN adds the err completion signal.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface timer_scheduler_if #(
    parameter int VALUE_W = 4
);
    logic               req_valid;
    logic [VALUE_W-1:0] req_value;
    logic               req_ready;
    logic               tmr_clear;
    logic               tmr_start;
    logic [VALUE_W-1:0] tmr_value;
    logic               tmr_out;
    logic               done;
    logic [VALUE_W-1:0] done_value;
    logic               busy;
`ifdef WATCHDOG_EN
    logic               err;
`endif

    modport slave (
        input  req_valid,
        input  req_value,
        input  tmr_out,
        output req_ready,
        output tmr_clear,
        output tmr_start,
        output tmr_value,
        output done,
        output done_value,
`ifdef WATCHDOG_EN
        output err,
`endif
        output busy
    );

    modport master (
        output req_valid,
        output req_value,
        output tmr_out,
        input  req_ready,
        input  tmr_clear,
        input  tmr_start,
        input  tmr_value,
        input  done,
        input  done_value,
`ifdef WATCHDOG_EN
        input  err,
`endif
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/timer_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_scheduler                                                  |
// | Queues delay requests and runs them on a one-shot timer in turn. |
// | Option: WATCHDOG_EN adds err output and a WAIT-state timeout.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module timer_scheduler #(
    parameter int DEPTH   = 4,
    parameter int VALUE_W = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    timer_scheduler_if.slave bus
);
    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0]   C_FULL = (PTR_W + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [VALUE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_timeout;

    logic               r_tmr_clear;
    logic               r_tmr_start;
    logic [VALUE_W-1:0] r_tmr_value;
    logic               r_done;
    logic [VALUE_W-1:0] r_done_value;
    logic               w_clear_nxt;
    logic               w_start_nxt;
    logic               w_done_nxt;
    logic [VALUE_W-1:0] w_value_nxt;

    assign w_ready = (r_count != C_FULL);
    assign w_push  = bus.req_valid & w_ready;
    assign w_pop   = (r_state == S_IDLE) && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.req_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WATCHDOG_EN
    localparam int WD_LIMIT = (1 << VALUE_W) + 4;
    localparam int WD_W     = $clog2(WD_LIMIT);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    // Counter restarts on every entry to WAIT so each job gets the full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !bus.tmr_out &&
                       (r_wd_cnt == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_timeout;
    end

    assign bus.err = r_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tmr_clear  <= 1'b1;
            r_tmr_start  <= 1'b0;
            r_tmr_value  <= '0;
            r_done       <= 1'b0;
            r_done_value <= '0;
        end else begin
            r_state     <= w_next;
            r_tmr_clear <= w_clear_nxt;
            r_tmr_start <= w_start_nxt;
            r_tmr_value <= w_value_nxt;
            r_done      <= w_done_nxt;
            if (w_done_nxt) r_done_value <= r_tmr_value;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_next = S_CLEAR;
            S_CLEAR: w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (bus.tmr_out || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        w_clear_nxt = !((w_next == S_START) || (w_next == S_WAIT));
        w_start_nxt = (w_next == S_START);
        w_done_nxt  = (r_state == S_WAIT) && bus.tmr_out;
        w_value_nxt = w_pop ? r_mem[r_rd_ptr] : r_tmr_value;
    end

    assign bus.req_ready  = w_ready;
    assign bus.tmr_clear  = r_tmr_clear;
    assign bus.tmr_start  = r_tmr_start;
    assign bus.tmr_value  = r_tmr_value;
    assign bus.done       = r_done;
    assign bus.done_value = r_done_value;
    assign bus.busy       = (r_state != S_IDLE) || (r_count != '0);
endmodule
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_timer_scheduler                                               |
// | Scoreboard bench with a behavioural one-shot timer model.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_timer_scheduler;
    localparam int DEPTH   = 4;
    localparam int VALUE_W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    timer_scheduler_if #(.VALUE_W(VALUE_W)) dif ();

    timer_scheduler #(
        .DEPTH   (DEPTH),
        .VALUE_W (VALUE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    int                 n_checks = 0;
    int                 n_errors = 0;
    logic [VALUE_W-1:0] exp_q [$];
    bit                 hold = 1'b0;
    bit                 t_act;
    int                 t_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor first, then timer model: done is judged against the tmr_out the DUT sampled.
    initial begin
        dif.tmr_out = 1'b0;
        t_act = 1'b0;
        t_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dif.done) begin
                    check("done_after_out", dif.tmr_out, 1);
                    if (exp_q.size() == 0) check("done_unexpected", 1, 0);
                    else                   check("done_value", dif.done_value, exp_q.pop_front());
                end
`ifdef WATCHDOG_EN
                if (dif.err) begin
                    check("err_without_done", dif.done, 0);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
`endif
            end
            if (reset || dif.tmr_clear) begin
                dif.tmr_out = 1'b0;
                t_act = 1'b0;
            end else if (dif.tmr_start) begin
                t_act = 1'b1;
                t_cnt = int'(dif.tmr_value);
            end else if (t_act && !hold) begin
                if (t_cnt == 0) dif.tmr_out = 1'b1;
                else            t_cnt--;
            end
        end
    end

    task automatic push(input logic [VALUE_W-1:0] v);
        dif.req_valid = 1'b1;
        dif.req_value = v;
        if (dif.req_ready) exp_q.push_back(v);
        @(negedge clk);
        dif.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dif.done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!dif.busy) return;
        end
        check("idle_timeout", 1, 0);
    endtask

    initial begin
        dif.req_valid = 1'b0;
        dif.req_value = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", dif.req_ready, 1);
        check("rst_busy", dif.busy, 0);
        check("rst_clear", dif.tmr_clear, 1);
        check("rst_start", dif.tmr_start, 0);
        check("rst_value", dif.tmr_value, 0);
        check("rst_done", dif.done, 0);
        check("rst_done_value", dif.done_value, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_clear", dif.tmr_clear, 1);
        check("idle_busy", dif.busy, 0);

        // Single job: start pulse lands two cycles after the push edge.
        push(4'd3);
        check("busy_queued", dif.busy, 1);
        check("start_n0", dif.tmr_start, 0);
        @(negedge clk);
        check("clear_in_clear", dif.tmr_clear, 1);
        check("start_n1", dif.tmr_start, 0);
        check("value_latched", dif.tmr_value, 3);
        @(negedge clk);
        check("start_n2", dif.tmr_start, 1);
        check("clear_in_start", dif.tmr_clear, 0);
        @(negedge clk);
        check("start_once", dif.tmr_start, 0);
        wait_done(50);
        wait_idle(10);
        check("value_held", dif.tmr_value, 3);

        // Fill the FIFO behind a stalled job; a push while full must be dropped.
        hold = 1'b1;
        push(4'd7);
        repeat (4) @(negedge clk);
        push(4'd5);
        push(4'd1);
        push(4'd0);
        push(4'd9);
        check("ready_full", dif.req_ready, 0);
        push(4'd15);
        check("ready_still_full", dif.req_ready, 0);
        hold = 1'b0;
        repeat (5) wait_done(100);
        wait_idle(20);
        check("order_drained", exp_q.size(), 0);

        // Push on the same edge as a pop with three entries queued.
        hold = 1'b1;
        push(4'd2);
        repeat (4) @(negedge clk);
        push(4'd6);
        push(4'd10);
        push(4'd12);
        check("ready_three", dif.req_ready, 1);
        hold = 1'b0;
        wait_done(100);
        @(negedge clk);
        push(4'd13);
        check("ready_pop_push", dif.req_ready, 1);
        push(4'd14);
        check("ready_after_fill", dif.req_ready, 0);
        repeat (5) wait_done(100);
        wait_idle(20);

        // Ten streamed jobs carry both pointers through several wraps.
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 100 && !dif.req_ready; k++) @(negedge clk);
            push(VALUE_W'($urandom_range(0, 15)));
        end
        wait_idle(2000);
        check("stream_drained", exp_q.size(), 0);

        // Reset in WAIT with two queued jobs discards everything.
        hold = 1'b1;
        push(4'd8);
        repeat (4) @(negedge clk);
        push(4'd4);
        push(4'd11);
        #2 reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_busy", dif.busy, 0);
        check("mid_rst_ready", dif.req_ready, 1);
        check("mid_rst_clear", dif.tmr_clear, 1);
        check("mid_rst_done", dif.done, 0);
        #2 reset = 1'b0;
        hold = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_busy", dif.busy, 0);
        check("post_rst_clear", dif.tmr_clear, 1);
        push(4'd6);
        wait_done(60);
        wait_idle(10);

`ifdef WATCHDOG_EN
        begin
            int k;
            hold = 1'b1;
            push(4'd5);
            for (int i = 0; i < 10 && !dif.tmr_start; i++) @(negedge clk);
            k = 0;
            while (!dif.err && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("wd_latency", k, 21);
            hold = 1'b0;
            wait_idle(10);
            push(4'd2);
            wait_done(60);
            wait_idle(10);
        end
`endif

        check("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end
endmodule
`default_nettype wire
